// File: rtl/decode_stage_p.sv
// Parameterised decode stage: register file with writeback bypass, load-use
// bubble insertion, flushable valid/ready ID/EX register and a stall counter.
module decode_stage_p #(
    parameter int unsigned DW       = 16,
    parameter int unsigned NREG     = 8,
    parameter int unsigned AW       = 3,
    parameter int unsigned CW       = 15,
    parameter bit          ZERO_REG = 1'b0,
    parameter bit          BYPASS   = 1'b1,
    parameter int unsigned CNTW     = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   id_rs,
    input  logic [AW-1:0]   id_rt,
    input  logic [AW-1:0]   id_wr,
    input  logic            id_regwrite,
    input  logic            id_memread,
    input  logic            id_uses_rt,
    input  logic [CW-1:0]   id_ctrl,
    input  logic [DW-1:0]   id_imm,
    input  logic [DW-1:0]   id_pc,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [DW-1:0]   wb_data,
    input  logic            flush,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [DW-1:0]   ex_rd1,
    output logic [DW-1:0]   ex_rd2,
    output logic [AW-1:0]   ex_rs,
    output logic [AW-1:0]   ex_rt,
    output logic [AW-1:0]   ex_wr,
    output logic            ex_regwrite,
    output logic            ex_memread,
    output logic [CW-1:0]   ex_ctrl,
    output logic [DW-1:0]   ex_imm,
    output logic [DW-1:0]   ex_pc,
    output logic            hazard,
    output logic [CNTW-1:0] stall_cnt,
    output logic            err
);

    typedef struct packed {
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [AW-1:0] wr;
        logic          regwrite;
        logic          memread;
        logic [CW-1:0] ctrl;
        logic [DW-1:0] imm;
        logic [DW-1:0] pc;
    } idex_t;

    logic [DW-1:0]   rf [NREG];
    idex_t           ex_q, ex_d;
    logic            ex_valid_q, ex_valid_d;
    logic [CNTW-1:0] stall_cnt_q;
    logic            err_q;

    logic            rs_legal, rt_legal, wb_legal, wb_we;
    logic            rd_illegal, advance, ex_wr_zero;
    logic [DW-1:0]   rd1_c, rd2_c;

    function automatic logic addr_legal(input logic [AW-1:0] a);
        return 32'(a) < NREG;
    endfunction

    // One read port: array lookup, then same-cycle writeback bypass, then r0 override.
    function automatic logic [DW-1:0] read_port(
        input logic [AW-1:0] a,
        input logic [DW-1:0] regs [NREG],
        input logic          wen,
        input logic [AW-1:0] waddr,
        input logic [DW-1:0] wdata
    );
        logic [DW-1:0] v;
        v = '0;
        for (int i = 0; i < int'(NREG); i++) begin
            if (a == AW'(i)) v = regs[i];
        end
        if (BYPASS && wen && waddr == a && addr_legal(a)) v = wdata;
        if (ZERO_REG && a == '0) v = '0;
        return v;
    endfunction

    assign rs_legal   = addr_legal(id_rs);
    assign rt_legal   = addr_legal(id_rt);
    assign wb_legal   = addr_legal(wb_addr);
    assign wb_we      = wb_en && wb_legal && !(ZERO_REG && wb_addr == '0);
    assign rd_illegal = in_valid && (!rs_legal || (id_uses_rt && !rt_legal));

    assign rd1_c = read_port(id_rs, rf, wb_en, wb_addr, wb_data);
    assign rd2_c = read_port(id_rt, rf, wb_en, wb_addr, wb_data);

    // Load-use: a load in EX whose destination feeds this instruction.
    assign ex_wr_zero = ZERO_REG && ex_q.wr == '0;
    assign hazard     = in_valid && ex_valid_q && ex_q.memread && ex_q.regwrite && !ex_wr_zero
                        && ((ex_q.wr == id_rs) || (id_uses_rt && ex_q.wr == id_rt));
    assign advance    = ex_ready || !ex_valid_q;
    assign in_ready   = advance && !hazard && !flush;

    always_comb begin
        ex_d       = ex_q;
        ex_valid_d = ex_valid_q;
        if (flush) begin
            ex_valid_d    = 1'b0;
            ex_d.regwrite = 1'b0;
            ex_d.memread  = 1'b0;
        end else if (advance) begin
            if (in_valid && !hazard) begin
                ex_valid_d    = 1'b1;
                ex_d.rd1      = rd1_c;
                ex_d.rd2      = rd2_c;
                ex_d.rs       = id_rs;
                ex_d.rt       = id_rt;
                ex_d.wr       = id_wr;
                ex_d.regwrite = id_regwrite;
                ex_d.memread  = id_memread;
                ex_d.ctrl     = id_ctrl;
                ex_d.imm      = id_imm;
                ex_d.pc       = id_pc;
            end else begin
                ex_valid_d    = 1'b0;
                ex_d.regwrite = 1'b0;
                ex_d.memread  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) rf[i] <= '0;
        end else begin
            for (int i = 0; i < int'(NREG); i++) begin
                if (wb_we && wb_addr == AW'(i)) rf[i] <= wb_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= '0;
            ex_valid_q  <= 1'b0;
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            ex_q       <= ex_d;
            ex_valid_q <= ex_valid_d;
            if (hazard && stall_cnt_q != {CNTW{1'b1}}) stall_cnt_q <= stall_cnt_q + CNTW'(1);
            if ((wb_en && !wb_legal) || rd_illegal) err_q <= 1'b1;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_rd1      = ex_q.rd1;
    assign ex_rd2      = ex_q.rd2;
    assign ex_rs       = ex_q.rs;
    assign ex_rt       = ex_q.rt;
    assign ex_wr       = ex_q.wr;
    assign ex_regwrite = ex_q.regwrite;
    assign ex_memread  = ex_q.memread;
    assign ex_ctrl     = ex_q.ctrl;
    assign ex_imm      = ex_q.imm;
    assign ex_pc       = ex_q.pc;
    assign stall_cnt   = stall_cnt_q;
    assign err         = err_q;

endmodule
